// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back staging FIFO feeding the register file, with RAW snoop forwarding
module writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [ADDR_WIDTH-1:0]   push_address,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    drain_enable,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [ADDR_WIDTH-1:0]   rf_address,
    output logic [DATA_WIDTH-1:0]   rf_data_in,
    output logic                    rf_write,
    input  logic [ADDR_WIDTH-1:0]   snoop_sel_a,
    input  logic [ADDR_WIDTH-1:0]   snoop_sel_b,
    output logic                    snoop_hit_a,
    output logic [DATA_WIDTH-1:0]   snoop_data_a,
    output logic                    snoop_hit_b,
    output logic [DATA_WIDTH-1:0]   snoop_data_b
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] XZR = ADDR_WIDTH'(31);

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic                  real_push;
    logic                  accept;

    assign empty      = count == '0;
    assign full       = count == CW'(DEPTH);
    assign rf_write   = drain_enable && !empty;
    assign rf_address = empty ? '0 : addr_mem[head];
    assign rf_data_in = empty ? '0 : data_mem[head];
    assign real_push  = push && push_address != XZR;
    assign accept     = real_push && (!full || rf_write);

    // Pointers, occupancy and sticky overflow; reset discards anything still pending.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) tail <= tail + 1'b1;
            if (rf_write) head <= head + 1'b1;
            count <= count + CW'(accept) - CW'(rf_write);
            if (real_push && !accept) overflow <= 1'b1;
        end
    end

    // Entry storage; occupancy alone defines which slots are valid, so no reset is needed.
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_mem[tail] <= push_address;
            data_mem[tail] <= push_data;
        end
    end

    // Walk occupied slots oldest to youngest so the last match (youngest) wins on each port.
    always_comb begin
        snoop_hit_a  = 1'b0;
        snoop_data_a = '0;
        snoop_hit_b  = 1'b0;
        snoop_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (snoop_sel_a != XZR && addr_mem[head + PW'(i)] == snoop_sel_a) begin
                    snoop_hit_a  = 1'b1;
                    snoop_data_a = data_mem[head + PW'(i)];
                end
                if (snoop_sel_b != XZR && addr_mem[head + PW'(i)] == snoop_sel_b) begin
                    snoop_hit_b  = 1'b1;
                    snoop_data_b = data_mem[head + PW'(i)];
                end
            end
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed stimulus with a queue-based reference model checked every cycle
module tb_writeback_queue;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic        drain_enable = 1'b0;
    logic [4:0]  push_address = '0;
    logic [63:0] push_data = '0;
    logic [4:0]  snoop_sel_a = '0;
    logic [4:0]  snoop_sel_b = '0;
    logic        full, empty, overflow, rf_write, snoop_hit_a, snoop_hit_b;
    logic [2:0]  count;
    logic [4:0]  rf_address;
    logic [63:0] rf_data_in, snoop_data_a, snoop_data_b;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_ovf = 1'b0;
    logic        cmp_en = 1'b0;
    logic        e_ha, e_hb;
    logic [63:0] e_da, e_db;
    int          checks = 0;
    int          failures = 0;

    writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .push(push), .push_address(push_address),
        .push_data(push_data), .drain_enable(drain_enable), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .rf_address(rf_address), .rf_data_in(rf_data_in),
        .rf_write(rf_write), .snoop_sel_a(snoop_sel_a), .snoop_sel_b(snoop_sel_b),
        .snoop_hit_a(snoop_hit_a), .snoop_data_a(snoop_data_a),
        .snoop_hit_b(snoop_hit_b), .snoop_data_b(snoop_data_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void snoop_model(input logic [4:0] sel, output logic hit, output logic [63:0] data);
        hit = 1'b0;
        data = '0;
        foreach (mq[i]) if (sel != 5'd31 && mq[i].a == sel) begin
            hit = 1'b1;
            data = mq[i].d;
        end
    endfunction

    // Reference model: a drop is a real push into a full queue that is not draining; pop precedes push.
    always @(posedge clock) begin
        if (!reset) begin
            mq.delete();
            m_ovf <= 1'b0;
        end else begin
            if (push && push_address != 5'd31 && mq.size() == DEPTH && !drain_enable) m_ovf <= 1'b1;
            if (drain_enable && mq.size() != 0) void'(mq.pop_front());
            if (push && push_address != 5'd31 && mq.size() < DEPTH) mq.push_back('{push_address, push_data});
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clock) begin
        if (cmp_en) begin
            snoop_model(snoop_sel_a, e_ha, e_da);
            snoop_model(snoop_sel_b, e_hb, e_db);
            chk("m_count", 64'(count), 64'(mq.size()));
            chk("m_empty", 64'(empty), 64'(mq.size() == 0));
            chk("m_full", 64'(full), 64'(mq.size() == DEPTH));
            chk("m_overflow", 64'(overflow), 64'(m_ovf));
            chk("m_rf_write", 64'(rf_write), 64'(drain_enable && mq.size() != 0));
            chk("m_rf_address", 64'(rf_address), mq.size() != 0 ? 64'(mq[0].a) : 64'd0);
            chk("m_rf_data_in", rf_data_in, mq.size() != 0 ? mq[0].d : 64'd0);
            chk("m_hit_a", 64'(snoop_hit_a), 64'(e_ha));
            chk("m_data_a", snoop_data_a, e_da);
            chk("m_hit_b", 64'(snoop_hit_b), 64'(e_hb));
            chk("m_data_b", snoop_data_b, e_db);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setin(input logic p, input logic [4:0] a, input logic [63:0] d, input logic de);
        push = p;
        push_address = a;
        push_data = d;
        drain_enable = de;
    endtask

    logic [4:0]  exp_addr [4] = '{5'd2, 5'd3, 5'd4, 5'd7};
    logic [63:0] exp_data [4] = '{64'hB, 64'hC, 64'hD, 64'hF0};

    initial begin
        tick();
        tick();
        cmp_en = 1'b1;
        reset = 1'b1;
        drain_enable = 1'b1;
        @(negedge clock);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rf_write", 64'(rf_write), 64'd0);
        chk("rst_rf_address", 64'(rf_address), 64'd0);
        chk("rst_rf_data", rf_data_in, 64'd0);
        chk("rst_hit_a", 64'(snoop_hit_a), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        tick();
        setin(1'b1, 5'd3, 64'h1111_2222_3333_4444, 1'b0);
        tick();
        setin(1'b0, 5'd0, 64'd0, 1'b0);
        @(negedge clock);
        chk("s1_count", 64'(count), 64'd1);
        chk("s1_empty", 64'(empty), 64'd0);
        chk("s1_rf_write_off", 64'(rf_write), 64'd0);
        tick();
        drain_enable = 1'b1;
        @(negedge clock);
        chk("s1_rf_write", 64'(rf_write), 64'd1);
        chk("s1_rf_address", 64'(rf_address), 64'd3);
        chk("s1_rf_data", rf_data_in, 64'h1111_2222_3333_4444);
        tick();
        drain_enable = 1'b0;
        @(negedge clock);
        chk("s1_count_after", 64'(count), 64'd0);
        chk("s1_empty_after", 64'(empty), 64'd1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            setin(1'b1, 5'(i), 64'(9 + i), 1'b0);
            tick();
        end
        setin(1'b1, 5'd7, 64'hF0, 1'b1);
        @(negedge clock);
        chk("s2_full", 64'(full), 64'd1);
        chk("s2_count", 64'(count), 64'd4);
        chk("s3_rf_address", 64'(rf_address), 64'd1);
        tick();
        setin(1'b1, 5'd5, 64'h55, 1'b0);
        @(negedge clock);
        chk("s3_count", 64'(count), 64'd4);
        chk("s3_overflow", 64'(overflow), 64'd0);
        tick();
        setin(1'b0, 5'd0, 64'd0, 1'b0);
        @(negedge clock);
        chk("s2_overflow", 64'(overflow), 64'd1);
        chk("s2_count_drop", 64'(count), 64'd4);
        tick();
        drain_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("s2_drain_address", 64'(rf_address), 64'(exp_addr[k]));
            chk("s2_drain_data", rf_data_in, exp_data[k]);
            tick();
        end
        drain_enable = 1'b0;
        @(negedge clock);
        chk("s2_empty", 64'(empty), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        snoop_sel_a = 5'd31;
        setin(1'b1, 5'd31, 64'hDEAD, 1'b0);
        tick();
        setin(1'b0, 5'd0, 64'd0, 1'b1);
        @(negedge clock);
        chk("s4_count", 64'(count), 64'd0);
        chk("s4_overflow", 64'(overflow), 64'd0);
        chk("s4_rf_write", 64'(rf_write), 64'd0);
        chk("s4_hit_a", 64'(snoop_hit_a), 64'd0);
        chk("s4_data_a", snoop_data_a, 64'd0);
        tick();
        setin(1'b1, 5'd2, 64'h10, 1'b0);
        tick();
        setin(1'b1, 5'd2, 64'h20, 1'b0);
        tick();
        setin(1'b0, 5'd0, 64'd0, 1'b0);
        snoop_sel_b = 5'd2;
        @(negedge clock);
        chk("s5_hit_b", 64'(snoop_hit_b), 64'd1);
        chk("s5_data_b", snoop_data_b, 64'h20);
        drain_enable = 1'b1;
        tick();
        @(negedge clock);
        chk("s5_hit_b_pop1", 64'(snoop_hit_b), 64'd1);
        chk("s5_data_b_pop1", snoop_data_b, 64'h20);
        tick();
        @(negedge clock);
        chk("s5_hit_b_pop2", 64'(snoop_hit_b), 64'd0);
        chk("s5_data_b_pop2", snoop_data_b, 64'd0);
        drain_enable = 1'b0;
        tick();
        setin(1'b1, 5'd8, 64'h80, 1'b0);
        tick();
        setin(1'b1, 5'd9, 64'h90, 1'b0);
        tick();
        setin(1'b1, 5'd10, 64'hA0, 1'b0);
        tick();
        setin(1'b0, 5'd0, 64'd0, 1'b1);
        reset = 1'b0;
        @(negedge clock);
        chk("s6_count_pre", 64'(count), 64'd3);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("s6_count", 64'(count), 64'd0);
        chk("s6_rf_write", 64'(rf_write), 64'd0);
        chk("s6_overflow", 64'(overflow), 64'd0);
        chk("s6_empty", 64'(empty), 64'd1);
        tick();
        tick();
        tick();
        @(negedge clock);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-back staging buffer directly upstream of the 32x64 register file; drives its data_in/address/write port.
- Accepts write-back requests (address, data) from the execute/memory stages and queues them in order.
- Drains one entry per cycle into the register file when the port is granted.
- Snoop ports let decode read the newest pending value for a register before it lands in the file. This is read-after-write forwarding.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2)
- DATA_WIDTH, 64, write-back data width
- ADDR_WIDTH, 5, register address width (32 registers; register 31 is XZR)

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- push  input  1  enqueue request
- push_address  input  ADDR_WIDTH  destination register of request
- push_data  input  DATA_WIDTH  value to write
- drain_enable  input  1  register-file write port granted this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  $clog2(DEPTH)+1  occupied entries
- overflow  output  1  sticky: a push was dropped
- rf_address  output  ADDR_WIDTH  to register file address
- rf_data_in  output  DATA_WIDTH  to register file data_in
- rf_write  output  1  to register file write
- snoop_sel_a  input  ADDR_WIDTH  decode read select A
- snoop_sel_b  input  ADDR_WIDTH  decode read select B
- snoop_hit_a  output  1  pending entry matches snoop_sel_a
- snoop_data_a  output  DATA_WIDTH  newest pending data for snoop_sel_a
- snoop_hit_b  output  1  same for B
- snoop_data_b  output  DATA_WIDTH  same for B

Behaviour:
- Reset: sampled on rising clock edge when reset==0. Clears head/tail pointers, count=0, overflow=0 and invalidates all entries. Pending writes are discarded, not drained.
- After reset: empty=1, full=0, rf_write=0, rf_address=0, rf_data_in=0, snoop_hit_a/b=0, snoop_data_a/b=0.
- Head outputs (combinational from head entry):
  - rf_write = drain_enable && !empty.
  - rf_address/rf_data_in = head entry when !empty; all-zero when empty.
- Pop: on an edge where rf_write==1 the head entry retires. The register file captures it on the same edge. Latency push->rf_write is 1 cycle minimum.
- Push acceptance:
  - Accepted when push==1 && push_address!=31 && (!full || rf_write). Full with a simultaneous pop is accepted.
  - Entry is visible at the head/snoop from the next cycle.
- XZR: push_address==31 is silently discarded. It is not enqueued, does not set overflow, and count is unchanged.
- Overflow: push==1, push_address!=31, full==1 and rf_write==0 drops the request and sets overflow=1. overflow clears only on reset.
- count next-state:
  - +1 on accepted push only.
  - -1 on pop only.
  - Unchanged on push+pop or on neither.
- Pointers: wrap modulo DEPTH. The extra count bit distinguishes full from empty.
- Order: strict FIFO; multiple pending writes to the same register drain in arrival order.
- Snoop (combinational, per port independently):
  - Hit if any valid entry's address == sel and sel != 31.
  - On a hit, data is from the youngest matching entry (closest to tail).
  - The head entry popping this cycle still counts as a hit.
  - A push in the current cycle is not visible until the next cycle.
  - On a miss, hit=0 and data=0.
- Empty/full outputs are derived from registered count; no combinational path from push to full/empty.

Test Plan:
- Reset then push (addr 3, 0x1111_2222_3333_4444) with drain_enable=0 -> next cycle count=1, empty=0, rf_write=0. Raise drain_enable -> rf_write=1, rf_address=3, rf_data_in=0x1111_2222_3333_4444; next edge count=0, empty=1.
- drain_enable=0, push addr 1..4 with data 0xA..0xD -> full=1, count=4. Push addr 5 -> dropped, overflow=1, count stays 4. Enable drain -> rf_address sequence 1,2,3,4 on consecutive cycles.
- Full queue, drain_enable=1 and push addr 7 data 0xF0 in the same cycle -> accepted, count stays 4, overflow=0. addr 7 drains fifth.
- Push addr 31 data 0xDEAD -> count unchanged, overflow=0, no rf_write. snoop_sel_a=31 -> hit_a=0, data_a=0.
- drain_enable=0, push addr 2 data 0x10 then addr 2 data 0x20 -> snoop_sel_b=2 gives hit_b=1, data_b=0x20. After one pop, data_b=0x20. After both pops, hit_b=0.
- Queue holding 3 entries, assert reset=0 for one edge while drain_enable=1 -> count=0, rf_write=0, no further register-file writes, overflow=0.
